// File: rtl/core_ctrl.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencing plus a retired-instruction counter.
// Latency: branch 3, ALU 4, store 4, load 5 cycles per instruction with zero-wait memory.
// Backpressure: FETCH and MEM hold while mem_ack=0; mem_ack is ignored when no request is raised.

`ifndef IMM_SEL_WIDTH
`define IMM_SEL_WIDTH 2
`endif
`ifndef IMM_SEL_I
`define IMM_SEL_I 0
`endif
`ifndef IMM_SEL_S
`define IMM_SEL_S 1
`endif
`ifndef IMM_SEL_B
`define IMM_SEL_B 2
`endif

module core_ctrl #(
  parameter int IMM_SEL_WIDTH = `IMM_SEL_WIDTH,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              instr,
  input  logic                     mem_ack,
  input  logic                     br_cond,
  output logic                     ir_we,
  output logic                     pc_we,
  output logic                     pc_sel,
  output logic [IMM_SEL_WIDTH-1:0] imm_sel,
  output logic                     alu_src_b,
  output logic                     rf_we,
  output logic                     wb_sel,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     mem_addr_sel,
  output logic                     illegal,
  output logic [2:0]               state,
  output logic [CNT_WIDTH-1:0]     retired
);

  localparam logic [IMM_SEL_WIDTH-1:0] IMM_I = IMM_SEL_WIDTH'(`IMM_SEL_I);
  localparam logic [IMM_SEL_WIDTH-1:0] IMM_S = IMM_SEL_WIDTH'(`IMM_SEL_S);
  localparam logic [IMM_SEL_WIDTH-1:0] IMM_B = IMM_SEL_WIDTH'(`IMM_SEL_B);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q;
  logic   is_r, is_i, is_ld, is_st, is_br, legal;

  assign is_r  = (instr[6:0] == OP_R);
  assign is_i  = (instr[6:0] == OP_I);
  assign is_ld = (instr[6:0] == OP_LOAD);
  assign is_st = (instr[6:0] == OP_STORE);
  assign is_br = (instr[6:0] == OP_BRANCH);
  assign legal = is_r | is_i | is_ld | is_st | is_br;

  always_comb begin
    state_d      = state_q;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    imm_sel      = IMM_I;
    alu_src_b    = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;

    if (state_q inside {DECODE, EXEC, MEM, WB}) begin
      if (is_st)      imm_sel = IMM_S;
      else if (is_br) imm_sel = IMM_B;
    end

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: state_d = legal ? EXEC : TRAP;
      EXEC: begin
        alu_src_b = is_i | is_ld | is_st;
        if (is_br) begin
          pc_we   = 1'b1;
          pc_sel  = br_cond;
          state_d = FETCH;
        end else if (is_r | is_i) begin
          state_d = WB;
        end else begin
          state_d = MEM;
        end
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_st;
        alu_src_b    = 1'b1;
        if (mem_ack) begin
          if (is_st) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we   = |instr[11:7];
        wb_sel  = is_ld;
        pc_we   = 1'b1;
        state_d = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase

    // Reset kills every strobe in the same cycle so an in-flight access cannot complete.
    if (rst) begin
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 1'b0;
      alu_src_b    = 1'b0;
      rf_we        = 1'b0;
      wb_sel       = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      retired   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE && !legal) illegal_q <= 1'b1;
      if (pc_we) retired <= retired + CNT_WIDTH'(1);
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed table-driven bench for core_ctrl (CNT_WIDTH=4 build so counter wrap is reachable).
module tb_core_ctrl;

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] SW  = 32'h0051A023;
  localparam logic [31:0] BEQ = 32'h00208463;
  localparam logic [31:0] LW  = 32'h0002A283;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] ILL = 32'h0000007F;

  typedef struct packed {
    logic [2:0] st;
    logic       ir, pcwe, pcsel;
    logic [1:0] imm;
    logic       asb, rfwe, wbsel, mreq, mwe, masel, ill;
    logic [3:0] ret;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        ack;
    logic        brc;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, mem_ack, br_cond;
  logic [31:0] instr;
  logic        ir_we, pc_we, pc_sel, alu_src_b, rf_we, wb_sel, mem_req, mem_we, mem_addr_sel, illegal;
  logic [1:0]  imm_sel;
  logic [2:0]  state;
  logic [3:0]  retired;

  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  core_ctrl #(.IMM_SEL_WIDTH(2), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ack(mem_ack), .br_cond(br_cond),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel),
    .alu_src_b(alu_src_b), .rf_we(rf_we), .wb_sel(wb_sel), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .illegal(illegal),
    .state(state), .retired(retired)
  );

  function automatic exp_t mk(input logic [2:0] st, input logic ir, pcwe, pcsel,
                              input logic [1:0] imm, input logic asb, rfwe, wbsel,
                              mreq, mwe, masel, ill, input logic [3:0] ret);
    return '{st, ir, pcwe, pcsel, imm, asb, rfwe, wbsel, mreq, mwe, masel, ill, ret};
  endfunction

  task automatic add(input logic r, input logic [31:0] ins, input logic a, b, input exp_t e);
    vec_t v;
    v.rst = r; v.instr = ins; v.ack = a; v.brc = b; v.e = e;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs, optionally compare outputs mid-cycle, then step past the edge.
  task automatic cyc(input string nm, input logic r, input logic [31:0] ins,
                     input logic a, b, input logic do_chk, input exp_t e);
    exp_t act;
    rst = r; instr = ins; mem_ack = a; br_cond = b;
    @(negedge clk);
    if (do_chk) begin
      act = '{state, ir_we, pc_we, pc_sel, imm_sel, alu_src_b, rf_we, wb_sel,
              mem_req, mem_we, mem_addr_sel, illegal, retired};
      n_chk++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr = ADD; mem_ack = 1'b0; br_cond = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset, then ADD x3 with zero-wait memory
    add(1, ADD, 1, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    add(0, ADD, 1, 0, mk(0,1,0,0,0,0,0,0,1,0,0,0,0));
    add(0, ADD, 1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    add(0, ADD, 1, 0, mk(2,0,0,0,0,0,0,0,0,0,0,0,0));
    add(0, ADD, 1, 0, mk(4,0,1,0,0,0,1,0,0,0,0,0,0));
    // SW
    add(0, SW,  1, 0, mk(0,1,0,0,0,0,0,0,1,0,0,0,1));
    add(0, SW,  1, 0, mk(1,0,0,0,1,0,0,0,0,0,0,0,1));
    add(0, SW,  1, 0, mk(2,0,0,0,1,1,0,0,0,0,0,0,1));
    add(0, SW,  1, 0, mk(3,0,1,0,1,1,0,0,1,1,1,0,1));
    // BEQ taken
    add(0, BEQ, 1, 1, mk(0,1,0,0,0,0,0,0,1,0,0,0,2));
    add(0, BEQ, 1, 1, mk(1,0,0,0,2,0,0,0,0,0,0,0,2));
    add(0, BEQ, 1, 1, mk(2,0,1,1,2,0,0,0,0,0,0,0,2));
    // LW with one fetch wait and two MEM waits
    add(0, LW,  0, 0, mk(0,0,0,0,0,0,0,0,1,0,0,0,3));
    add(0, LW,  1, 0, mk(0,1,0,0,0,0,0,0,1,0,0,0,3));
    add(0, LW,  1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,3));
    add(0, LW,  1, 0, mk(2,0,0,0,0,1,0,0,0,0,0,0,3));
    add(0, LW,  0, 0, mk(3,0,0,0,0,1,0,0,1,0,1,0,3));
    add(0, LW,  0, 0, mk(3,0,0,0,0,1,0,0,1,0,1,0,3));
    add(0, LW,  1, 0, mk(3,0,0,0,0,1,0,0,1,0,1,0,3));
    add(0, LW,  1, 0, mk(4,0,1,0,0,0,1,1,0,0,0,0,3));
    // ADDI x0: write-back suppressed for rd=0
    add(0, NOP, 1, 0, mk(0,1,0,0,0,0,0,0,1,0,0,0,4));
    add(0, NOP, 1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,4));
    add(0, NOP, 1, 0, mk(2,0,0,0,0,1,0,0,0,0,0,0,4));
    add(0, NOP, 1, 0, mk(4,0,1,0,0,0,0,0,0,0,0,0,4));
    // BEQ not taken
    add(0, BEQ, 1, 0, mk(0,1,0,0,0,0,0,0,1,0,0,0,5));
    add(0, BEQ, 1, 0, mk(1,0,0,0,2,0,0,0,0,0,0,0,5));
    add(0, BEQ, 1, 0, mk(2,0,1,0,2,0,0,0,0,0,0,0,5));
    // illegal opcode fetched and decoded
    add(0, ILL, 1, 0, mk(0,1,0,0,0,0,0,0,1,0,0,0,6));
    add(0, ILL, 1, 0, mk(1,0,0,0,0,0,0,0,0,0,0,0,6));

    foreach (tbl[i])
      cyc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].instr, tbl[i].ack, tbl[i].brc, 1'b1, tbl[i].e);

    for (int i = 0; i < 10; i++)
      cyc($sformatf("trap%0d", i), 0, ILL, 1, 1, 1'b1, mk(5,0,0,0,0,0,0,0,0,0,0,1,6));
    cyc("trap_rst", 1, ILL, 1, 0, 1'b1, mk(5,0,0,0,0,0,0,0,0,0,0,1,6));
    cyc("post_trap_fetch", 0, ADD, 1, 0, 1'b1, mk(0,1,0,0,0,0,0,0,1,0,0,0,0));
    cyc("add2_dec", 0, ADD, 1, 0, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("add2_exec", 0, ADD, 1, 0, 1'b1, mk(2,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("add2_wb", 0, ADD, 1, 0, 1'b1, mk(4,0,1,0,0,0,1,0,0,0,0,0,0));

    // reset lands in MEM together with mem_ack: store must not retire
    cyc("sw2_fetch", 0, SW, 1, 0, 1'b1, mk(0,1,0,0,0,0,0,0,1,0,0,0,1));
    cyc("sw2_dec", 0, SW, 1, 0, 1'b1, mk(1,0,0,0,1,0,0,0,0,0,0,0,1));
    cyc("sw2_exec", 0, SW, 1, 0, 1'b1, mk(2,0,0,0,1,1,0,0,0,0,0,0,1));
    cyc("sw2_mem_rst", 1, SW, 1, 0, 1'b1, mk(3,0,0,0,1,0,0,0,0,0,0,0,1));
    cyc("rst_fetch", 0, BEQ, 1, 1, 1'b1, mk(0,1,0,0,0,0,0,0,1,0,0,0,0));

    // sixteen branches: counter reaches all-ones then wraps to zero
    for (int i = 1; i <= 16; i++) begin
      cyc("wrap_dec", 0, BEQ, 1, 1, 1'b0, '0);
      cyc("wrap_exec", 0, BEQ, 1, 1, 1'b0, '0);
      cyc($sformatf("wrap%0d", i), 0, BEQ, 1, 1, 1'b1, mk(0,1,0,0,0,0,0,0,1,0,0,0,4'(i)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
